usb_rx_phy: RTL and testbench

USB_RX_PHY -- requirements
Module: usb_rx_phy

---
 rtl/usb_rx_phy.sv | 189 ++++++++++++++++++
 tb/tb_usb_rx_phy.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_phy.sv
// rtl/usb_rx_phy.sv - full-speed USB receive PHY: line sync, DPLL phase, NRZI decode, unstuff, byte assembly
//
// Purpose: recovers bytes from the D+/D- pair at 4x oversampling (48 MHz clk, 12 Mbit/s line).
// Ports:
//   clk        48 MHz system clock
//   rst        synchronous active-high reset
//   dp_i/dn_i  asynchronous D+/D- line levels
//   rx_en      receive enable (low while the device transmits)
//   rx_data    last received byte, LSB first on the wire, held between strobes
//   rx_valid   one-cycle strobe qualifying rx_data
//   rx_active  high from SYNC completion until packet end or abort
//   rx_err     one-cycle strobe on a receive error
//   line_state synchronised {dp,dn}: 10=J, 01=K, 00=SE0, 11=SE1
// Build option: define USB_RX_STUFF_ERR_EN to treat a 1 in a stuffed-bit slot as an error.
module usb_rx_phy #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dp_i,
    input  logic       dn_i,
    input  logic       rx_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_err,
    output logic [1:0] line_state
);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_t;

    logic [SYNC_STAGES-1:0] dp_sync_q, dn_sync_q;
    logic [1:0] ls, ls_prev_q;
    logic [1:0] phase_q, phase_cur;
    logic       line_edge, sample, bit_one;

    state_t     state_q, state_d;
    logic [1:0] prev_level_q, prev_level_d;
    logic [2:0] zero_cnt_q, zero_cnt_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_err_q, rx_err_d;

    assign ls = {dp_sync_q[SYNC_STAGES-1], dn_sync_q[SYNC_STAGES-1]};

    // Only J<->K changes re-align the bit clock; SE0/SE1 excursions let it free-run.
    assign line_edge = ((ls == LS_J) && (ls_prev_q == LS_K)) ||
                       ((ls == LS_K) && (ls_prev_q == LS_J));
    // The edge cycle itself is phase 0, so the sample lands two clocks into the bit,
    // which tolerates 3..5 clock bit periods.
    assign phase_cur = line_edge ? 2'd0 : phase_q + 2'd1;
    assign sample    = (phase_cur == 2'd2);
    assign bit_one   = (ls == prev_level_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sync_q    <= '0;
            dn_sync_q    <= '0;
            ls_prev_q    <= LS_SE0;
            phase_q      <= 2'd0;
            state_q      <= ST_IDLE;
            prev_level_q <= LS_J;
            zero_cnt_q   <= 3'd0;
            ones_cnt_q   <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            dp_sync_q    <= {dp_sync_q[SYNC_STAGES-2:0], dp_i};
            dn_sync_q    <= {dn_sync_q[SYNC_STAGES-2:0], dn_i};
            ls_prev_q    <= ls;
            phase_q      <= phase_cur;
            state_q      <= state_d;
            prev_level_q <= prev_level_d;
            zero_cnt_q   <= zero_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_err_q     <= rx_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_level_d = sample ? ls : prev_level_q;
        zero_cnt_d   = zero_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prev_level_d = LS_J;
                zero_cnt_d   = 3'd0;
                ones_cnt_d   = 3'd0;
                bit_cnt_d    = 3'd0;
                if (ls == LS_K) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (sample) begin
                    if ((ls == LS_SE0) || (ls == LS_SE1)) begin
                        state_d = ST_IDLE;
                    end else if (bit_one) begin
                        if (zero_cnt_q >= 3'd5) begin
                            state_d    = ST_DATA;
                            // The closing 1 of SYNC already counts toward the stuffing run.
                            ones_cnt_d = 3'd1;
                            bit_cnt_d  = 3'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (zero_cnt_q != 3'd5) begin
                        zero_cnt_d = zero_cnt_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (ls == LS_SE0) begin
                        state_d  = ST_EOP;
                        rx_err_d = (bit_cnt_q != 3'd0);
                    end else if (ls == LS_SE1) begin
                        state_d  = ST_IDLE;
                        rx_err_d = 1'b1;
                    end else if (ones_cnt_q == 3'd6) begin
                        ones_cnt_d = 3'd0;
`ifdef USB_RX_STUFF_ERR_EN
                        if (bit_one) begin
                            state_d  = ST_IDLE;
                            rx_err_d = 1'b1;
                        end
`else
                        // A 1 in the stuffed slot is dropped just like the expected 0.
`endif
                    end else begin
                        shift_d    = {bit_one, shift_q[7:1]};
                        ones_cnt_d = bit_one ? ones_cnt_q + 3'd1 : 3'd0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {bit_one, shift_q[7:1]};
                            rx_valid_d = 1'b1;
                        end
                    end
                end
            end
            ST_EOP: begin
                if (ls == LS_J) begin
                    state_d = ST_IDLE;
                end else if ((ls == LS_K) || (ls == LS_SE1)) begin
                    state_d  = ST_IDLE;
                    rx_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Transmit turnaround wins over everything and aborts silently.
        if (!rx_en) begin
            state_d    = ST_IDLE;
            rx_data_d  = rx_data_q;
            rx_valid_d = 1'b0;
            rx_err_d   = 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_err     = rx_err_q;
    assign rx_active  = (state_q == ST_DATA) || (state_q == ST_EOP);
    assign line_state = ls;

endmodule

// File: tb/tb_usb_rx_phy.sv
// tb/tb_usb_rx_phy.sv - scoreboard bench for usb_rx_phy
module tb_usb_rx_phy;

    logic       clk = 1'b0;
    logic       rst;
    logic       dp_i, dn_i, rx_en;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, rx_err;
    logic [1:0] line_state;

    always #10 clk = ~clk;

    usb_rx_phy #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dp_i       (dp_i),
        .dn_i       (dn_i),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .rx_err     (rx_err),
        .line_state (line_state)
    );

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         checks   = 0;
    int         failures = 0;
    int         rises    = 0;
    int         falls    = 0;
    logic       act_prev = 1'b0;
    logic [1:0] lvl;
    int         ones_tx;
    int         r0, f0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_err) begin
                checks++;
                failures++;
                $display("FAIL valid_err_overlap actual=11 required=not both");
            end
            if (rx_valid || rx_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual valid=%0b err=%0b data=%02h required=none",
                             rx_valid, rx_err, rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_is_err", {31'd0, rx_err}, {31'd0, mon_e.is_err});
                    if (!mon_e.is_err) check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
                end
            end
            if (rx_active && !act_prev) rises++;
            if (!rx_active && act_prev) falls++;
        end
        act_prev <= rx_active;
    end

    task automatic hold(input logic [1:0] ls, input int n);
        dp_i = ls[1];
        dn_i = ls[0];
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input int per);
        if (!b) lvl = (lvl == J) ? K : J;
        hold(lvl, per);
    endtask

    task automatic send_sync();
        lvl = J;
        for (int i = 0; i < 7; i++) send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        ones_tx = 1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int p_even, input int p_odd);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], (i % 2 == 1) ? p_odd : p_even);
            if (v[i]) ones_tx++;
            else ones_tx = 0;
            if (ones_tx == 6) begin
                send_bit(1'b0, 4);
                ones_tx = 0;
            end
        end
    endtask

    task automatic send_eop();
        hold(SE0, 8);
        lvl = J;
        hold(J, 8);
    endtask

    task automatic expect_byte(input logic [7:0] v);
        exp_q.push_back(ev_t'{is_err: 1'b0, data: v});
    endtask

    task automatic expect_err();
        exp_q.push_back(ev_t'{is_err: 1'b1, data: 8'h00});
    endtask

    task automatic finish_test(input string name);
        repeat (4) @(posedge clk);
        #2;
        check({name, "_pending_events"}, exp_q.size(), 0);
        check({name, "_rx_active_end"}, {31'd0, rx_active}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst   = 1'b1;
        rx_en = 1'b1;
        dp_i  = 1'b1;
        dn_i  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_active", {31'd0, rx_active}, 32'd0);
        check("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check("rst_line_state", {30'd0, line_state}, 32'd0);
        rst = 1'b0;
        lvl = J;
        hold(J, 10);
        check("idle_line_state", {30'd0, line_state}, {30'd0, J});

        // Basic packet 0xA5
        r0 = rises; f0 = falls;
        expect_byte(8'hA5);
        send_sync();
        send_byte(8'hA5, 4, 4);
        send_eop();
        finish_test("a5");
        check("a5_active_rises", rises - r0, 1);
        check("a5_active_falls", falls - f0, 1);

        // Two 0xFF bytes with stuffed zeros on the wire
        expect_byte(8'hFF);
        expect_byte(8'hFF);
        send_sync();
        send_byte(8'hFF, 4, 4);
        send_byte(8'hFF, 4, 4);
        send_eop();
        finish_test("ff");
        check("ff_rx_data_held", {24'd0, rx_data}, 32'hFF);

        // Seven ones after SYNC (no stuffing on the wire)
`ifdef USB_RX_STUFF_ERR_EN
        expect_err();
`endif
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 4);
        repeat (4) @(posedge clk);
        #2;
`ifdef USB_RX_STUFF_ERR_EN
        check("stuff7_active", {31'd0, rx_active}, 32'd0);
`else
        check("stuff7_active", {31'd0, rx_active}, 32'd1);
`endif
        rx_en = 1'b0;
        @(posedge clk);
        #2;
        check("stuff7_abort_active", {31'd0, rx_active}, 32'd0);
        lvl = J;
        hold(J, 8);
        rx_en = 1'b1;
        hold(J, 4);
        finish_test("stuff7");

        // Three data bits then SE0
        r0 = rises; f0 = falls;
        expect_err();
        send_sync();
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        send_eop();
        finish_test("partial_eop");
        check("partial_eop_falls", falls - f0, 1);

        // rx_en dropped after twelve data bits
        expect_byte(8'h5A);
        send_sync();
        send_byte(8'h5A, 4, 4);
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        repeat (2) @(posedge clk);
        #2;
        check("rxen_active_before", {31'd0, rx_active}, 32'd1);
        rx_en = 1'b0;
        @(posedge clk);
        #2;
        check("rxen_active_after", {31'd0, rx_active}, 32'd0);
        lvl = J;
        hold(J, 8);
        rx_en = 1'b1;
        finish_test("rxen_drop");

        // 0x3C with alternating 3/5 clock bit periods
        expect_byte(8'h3C);
        send_sync();
        send_byte(8'h3C, 3, 5);
        send_eop();
        finish_test("jitter");

        // SE1 at a data sample point
        expect_err();
        send_sync();
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        hold(SE1, 4);
        repeat (2) @(posedge clk);
        #2;
        check("se1_active", {31'd0, rx_active}, 32'd0);
        lvl = J;
        hold(J, 8);
        finish_test("se1");

        // Reset mid-packet, then a clean packet
        send_sync();
        send_bit(1'b1, 4);
        send_bit(1'b0, 4);
        rst = 1'b1;
        hold(lvl, 2);
        check("midrst_active", {31'd0, rx_active}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
        rst = 1'b0;
        lvl = J;
        hold(J, 16);
        expect_byte(8'h81);
        send_sync();
        send_byte(8'h81, 4, 4);
        send_eop();
        finish_test("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
